// File: rtl/once_window_buf_monitor.sv
// Bounded-past MTL monitor: once[A,B] p (MODE=0) or historically[A,B] p (MODE=1).
// The monitor stores up to DEPTH runs of p=1 as intervals in a circular buffer.
// Each interval records the age of its first 1 (sage) and the age of its last 1 (eage).
// Both ages saturate at B+1.
// The verdict is true when some interval overlaps the age window [A,B].
// When the buffer cannot hold another run, the newest interval is stretched to cover the
// new run, and the sticky ovf flag is set.
module once_window_buf_monitor #(
    parameter int unsigned A     = 0,
    parameter int unsigned B     = 1,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned MODE  = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic XXX,
    output logic sat,
    output logic err,
    output logic ovf
);

    localparam int unsigned AW = $clog2(B + 2);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [AW-1:0] AgeMax  = AW'(B + 1);
    localparam logic [AW-1:0] WinHi   = AW'(B);
    localparam logic [AW-1:0] WinLo   = AW'(A);
    localparam logic [PW-1:0] PtrLast = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CntFull = CW'(DEPTH);
    localparam logic          InvMode = (MODE != 0);

    typedef struct packed {
        logic          valid;
        logic          open;
        logic [AW-1:0] sage;
        logic [AW-1:0] eage;
    } entry_t;

    entry_t        ent_q [DEPTH];
    entry_t        ent_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          sat_q, sat_d;

    logic             p;
    logic [PW-1:0]    last;
    logic             tail_open;
    logic             push;
    logic [CW-1:0]    cnt_mid;
    logic [DEPTH-1:0] lo_ok;
    logic             once_hit;

    function automatic logic [AW-1:0] age_inc(input logic [AW-1:0] a);
        return (a == AgeMax) ? AgeMax : a + AW'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] q);
        return (q == PtrLast) ? '0 : q + PW'(1);
    endfunction

    // historically[A,B] p is evaluated as !once[A,B] !p
    assign p = XXX ^ InvMode;

    // tail_q is the next free slot, so the newest interval sits one slot behind it
    assign last      = (tail_q == '0) ? PtrLast : tail_q - PW'(1);
    assign tail_open = (cnt_q != '0) && ent_q[last].open;

    // Next buffer state: age, close, expire, then push or merge
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        cnt_mid = cnt_q;
        push    = 1'b0;

        // Age every stored interval; an open interval's last 1 is the current sample
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid) begin
                ent_d[i].sage = age_inc(ent_q[i].sage);
                if (!ent_q[i].open) begin
                    ent_d[i].eage = age_inc(ent_q[i].eage);
                end
            end
        end

        // The run ended: its last 1 was the previous sample
        if (!p && tail_open) begin
            ent_d[last].open = 1'b0;
            ent_d[last].eage = AW'(1);
        end

        push = p && !tail_open;

        // Only the oldest interval can have aged out of the window
        if (ent_d[head_q].valid && (ent_d[head_q].eage > WinHi)) begin
            ent_d[head_q].valid = 1'b0;
            head_d              = ptr_inc(head_q);
            cnt_mid             = cnt_q - CW'(1);
        end

        cnt_d = cnt_mid;
        if (push) begin
            if (cnt_mid == CntFull) begin
                // No room: stretch the newest interval to cover the new run
                ent_d[last].open = 1'b1;
                ent_d[last].eage = '0;
                ovf_d            = 1'b1;
            end else begin
                ent_d[tail_q] = '{valid: 1'b1, open: 1'b1, sage: '0, eage: '0};
                tail_d        = ptr_inc(tail_q);
                cnt_d         = cnt_mid + CW'(1);
            end
        end
    end

    // Lower-bound test on each entry's first-1 age; trivially true when A is 0
    if (A == 0) begin : g_lo_any
        assign lo_ok = '1;
    end else begin : g_lo_cmp
        always_comb begin
            for (int i = 0; i < DEPTH; i++) begin
                lo_ok[i] = (ent_d[i].sage >= WinLo);
            end
        end
    end

    // Verdict over the post-update entries
    always_comb begin
        once_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_d[i].valid && (ent_d[i].eage <= WinHi) && lo_ok[i]) begin
                once_hit = 1'b1;
            end
        end
        sat_d = once_hit ^ InvMode;
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            sat_q  <= InvMode;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            sat_q  <= sat_d;
        end
    end

    assign sat = sat_q;
    assign err = ~sat_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_once_window_buf_monitor.sv
// Directed bench: six monitor instances with different parameters share one clock.
// Each instance is driven from a per-edge vector table with hand-derived expected outputs.
module tb_once_window_buf_monitor;

    localparam int NV = 30;

    typedef struct {
        logic [5:0] x;
        logic [5:0] rst;
        logic [5:0] sat;
        logic [5:0] ovf;
    } vec_t;

    logic       clk;
    logic [5:0] rst;
    logic [5:0] x;
    logic [5:0] sat;
    logic [5:0] err;
    logic [5:0] ovf;

    int checks   = 0;
    int failures = 0;

    vec_t       vecs [NV];
    logic [5:0] rst_sat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: pulse window test
    once_window_buf_monitor #(.A(3), .B(6), .DEPTH(4), .MODE(0)) u_pulse (
        .clk(clk), .rst(rst[0]), .XXX(x[0]), .sat(sat[0]), .err(err[0]), .ovf(ovf[0])
    );
    // 1: run with A=0
    once_window_buf_monitor #(.A(0), .B(2), .DEPTH(4), .MODE(0)) u_run (
        .clk(clk), .rst(rst[1]), .XXX(x[1]), .sat(sat[1]), .err(err[1]), .ovf(ovf[1])
    );
    // 2: historically mode
    once_window_buf_monitor #(.A(2), .B(5), .DEPTH(4), .MODE(1)) u_hist (
        .clk(clk), .rst(rst[2]), .XXX(x[2]), .sat(sat[2]), .err(err[2]), .ovf(ovf[2])
    );
    // 3: overflow merge
    once_window_buf_monitor #(.A(0), .B(10), .DEPTH(2), .MODE(0)) u_ovf (
        .clk(clk), .rst(rst[3]), .XXX(x[3]), .sat(sat[3]), .err(err[3]), .ovf(ovf[3])
    );
    // 4: mid-run reset
    once_window_buf_monitor #(.A(1), .B(8), .DEPTH(4), .MODE(0)) u_mrst (
        .clk(clk), .rst(rst[4]), .XXX(x[4]), .sat(sat[4]), .err(err[4]), .ovf(ovf[4])
    );
    // 5: back-to-back alternating pulses
    once_window_buf_monitor #(.A(4), .B(4), .DEPTH(3), .MODE(0)) u_alt (
        .clk(clk), .rst(rst[5]), .XXX(x[5]), .sat(sat[5]), .err(err[5]), .ovf(ovf[5])
    );

    task automatic chk(input string name, input int inst, input int k,
                       input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d edge=%0d got=%0b want=%0b", name, inst, k, act, exp);
        end
    endtask

    initial begin
        // Edge k counts rising edges after reset release, starting at 0
        for (int k = 0; k < NV; k++) begin
            vecs[k].x[0]   = (k == 10);
            vecs[k].sat[0] = (k >= 13 && k <= 16);
            vecs[k].ovf[0] = 1'b0;

            vecs[k].x[1]   = (k >= 5 && k <= 8);
            vecs[k].sat[1] = (k >= 5 && k <= 10);
            vecs[k].ovf[1] = 1'b0;

            vecs[k].x[2]   = (k != 20);
            vecs[k].sat[2] = !(k >= 22 && k <= 25);
            vecs[k].ovf[2] = 1'b0;

            vecs[k].x[3]   = (k == 1 || k == 3 || k == 5);
            vecs[k].sat[3] = (k >= 1 && k <= 15);
            vecs[k].ovf[3] = (k >= 5);

            // The sample at edge 6 coincides with reset and must be ignored
            vecs[k].x[4]   = (k == 4 || k == 6);
            vecs[k].sat[4] = (k == 5);
            vecs[k].ovf[4] = 1'b0;

            vecs[k].x[5]   = (k < 20) && (k % 2 == 0);
            vecs[k].sat[5] = (k >= 4) && (k <= 22) && (k % 2 == 0);
            vecs[k].ovf[5] = 1'b0;

            vecs[k].rst    = 6'b000000;
            vecs[k].rst[4] = (k == 6);
        end
        rst_sat = 6'b000100;

        // Reset with the input held high: these samples must never count
        rst = 6'b111111;
        x   = 6'b111111;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("reset_sat", i, -1, sat[i], rst_sat[i]);
            chk("reset_err", i, -1, err[i], ~rst_sat[i]);
            chk("reset_ovf", i, -1, ovf[i], 1'b0);
        end

        for (int k = 0; k < NV; k++) begin
            x   = vecs[k].x;
            rst = vecs[k].rst;
            @(posedge clk);
            #1;
            for (int i = 0; i < 6; i++) begin
                chk("sat", i, k, sat[i], vecs[k].sat[i]);
                chk("err", i, k, err[i], ~vecs[k].sat[i]);
                chk("ovf", i, k, ovf[i], vecs[k].ovf[i]);
            end
        end

        // Sticky overflow clears only on reset
        x   = 6'b000000;
        rst = 6'b000000;
        @(posedge clk);
        #1;
        chk("ovf_sticky", 3, NV, ovf[3], 1'b1);
        rst = 6'b001000;
        @(posedge clk);
        #1;
        chk("ovf_rst", 3, NV + 1, ovf[3], 1'b0);
        chk("sat_rst", 3, NV + 1, sat[3], 1'b0);
        rst = 6'b000000;
        x   = 6'b001000;
        @(posedge clk);
        #1;
        chk("ovf_after_rst", 3, NV + 2, ovf[3], 1'b0);
        chk("sat_after_rst", 3, NV + 2, sat[3], 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
